// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller driving hold/bubble/kill per boundary,
// with a held fetch redirect, a stall-cycle counter and a stall watchdog.
module pipe_ctrl #(
   parameter int STAGES     = 5,
   parameter int CNT_W      = 32,
   parameter int WDOG_W     = 16,
   parameter int WDOG_LIMIT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [STAGES-1:0] stall_req,
   input  logic [STAGES-1:0] flush_req,
   input  logic              cnt_clr,
   output logic [STAGES-1:0] stall,
   output logic [STAGES-1:0] bubble,
   output logic [STAGES-1:0] kill,
   output logic              redirect_pending,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic              hang
);
   logic [STAGES-1:0] s, fl, kl, bb;
   logic              sacc, facc, req0;
   logic              fpend_q, fpend_d, hang_q, hang_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WDOG_W-1:0] consec_q, consec_d;
   always_comb begin
      s    = '0;
      kl   = '0;
      bb   = '0;
      sacc = 1'b0;
      facc = 1'b0;
      for (int i = STAGES-1; i >= 0; i--) begin
         sacc = sacc | stall_req[i];
         s[i] = sacc;
      end
      fl = flush_req & ~s & ~STAGES'(1);
      // kill[j] collects flushes strictly older than j; facc ends as the OR of all
      for (int j = STAGES-1; j >= 1; j--) begin
         kl[j] = facc;
         facc  = facc | fl[j];
      end
      req0  = facc | fpend_q;
      kl[0] = req0 & ~stall_req[0];
      for (int j = 1; j < STAGES; j++) bb[j] = s[j-1] & ~s[j] & ~kl[j];
      fpend_d  = req0 & stall_req[0];
      cnt_d    = cnt_clr ? '0 : (s[0] && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
      consec_d = !s[0] ? '0 : (consec_q != '1) ? consec_q + 1'b1 : consec_q;
      hang_d   = hang_q | (s[0] && consec_d == WDOG_W'(WDOG_LIMIT));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         fpend_q  <= 1'b0;
         cnt_q    <= '0;
         consec_q <= '0;
         hang_q   <= 1'b0;
      end else begin
         fpend_q  <= fpend_d;
         cnt_q    <= cnt_d;
         consec_q <= consec_d;
         hang_q   <= hang_d;
      end
   end
   assign stall            = rst ? '0 : s & ~kl;
   assign bubble           = rst ? '0 : bb;
   assign kill             = rst ? '0 : kl;
   assign redirect_pending = fpend_q & ~rst;
   assign stall_cnt        = rst ? '0 : cnt_q;
   assign hang             = hang_q & ~rst;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table, hand sequences and a randomized run against a behavioural model.
module tb_pipe_ctrl;
   localparam int S = 5;
   logic         clk = 1'b0, rst = 1'b1, cnt_clr = 1'b0;
   logic [S-1:0] stall_req = '0, flush_req = '0;
   logic [S-1:0] stall, bubble, kill;
   logic         redirect_pending, hang;
   logic [31:0]  stall_cnt;
   int           errors = 0, checks = 0;
   bit           fp_m, hang_m;
   longint       cnt_m;
   int           consec_m;

   pipe_ctrl dut (
      .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req), .cnt_clr(cnt_clr),
      .stall(stall), .bubble(bubble), .kill(kill), .redirect_pending(redirect_pending),
      .stall_cnt(stall_cnt), .hang(hang)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [S-1:0] sr, fr, es, eb, ek;
   } vec_t;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Oldest stall index bounds the stalled region; the oldest effective flush bounds the killed region.
   task automatic model(input logic [S-1:0] sr, input logic [S-1:0] fr, input bit fp,
                        output logic [S-1:0] es, output logic [S-1:0] eb,
                        output logic [S-1:0] ek, output bit req0);
      int os = -1, m = 0;
      for (int i = 0; i < S; i++) if (sr[i]) os = i;
      for (int i = 1; i < S; i++) if (fr[i] && i > os) m = i;
      req0 = (m > 0) || fp;
      for (int j = 0; j < S; j++) begin
         ek[j] = (j == 0) ? (req0 && !sr[0]) : (j < m);
         es[j] = (j <= os) && !ek[j];
         eb[j] = (j >= 1) && (j == os + 1) && !ek[j];
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; stall_req = '0; flush_req = '0; cnt_clr = 1'b0;
      tick();
      rst = 1'b0;
      fp_m = 0; hang_m = 0; cnt_m = 0; consec_m = 0;
   endtask

   vec_t vt[7];
   logic [S-1:0] es, eb, ek;
   bit           r0;

   initial begin
      vt[0] = '{5'b01000, 5'b00000, 5'b01111, 5'b10000, 5'b00000};
      vt[1] = '{5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00111};
      vt[2] = '{5'b10000, 5'b00100, 5'b11111, 5'b00000, 5'b00000};
      vt[3] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      vt[4] = '{5'b00100, 5'b10000, 5'b00000, 5'b00000, 5'b01111};
      vt[5] = '{5'b00010, 5'b00100, 5'b00000, 5'b00100, 5'b00011};
      vt[6] = '{5'b00001, 5'b00000, 5'b00001, 5'b00010, 5'b00000};

      // outputs forced low while in reset, regardless of requests
      stall_req = '1; flush_req = '1;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_kill", kill, 0);
      chk("rst_bubble", bubble, 0);
      tick();
      do_reset();
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_hang", hang, 0);
      chk("rst_pend", redirect_pending, 0);

      for (int v = 0; v < 7; v++) begin
         stall_req = vt[v].sr; flush_req = vt[v].fr;
         #1;
         chk($sformatf("vec%0d_stall", v), stall, vt[v].es);
         chk($sformatf("vec%0d_bubble", v), bubble, vt[v].eb);
         chk($sformatf("vec%0d_kill", v), kill, vt[v].ek);
         tick();
         chk($sformatf("vec%0d_pend", v), redirect_pending, 0);
      end

      do_reset();
      stall_req = 5'b01000;
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("cnt_step", stall_cnt, c);
      end

      // flush while fetch is stalled: redirect is held until stall_req[0] drops
      do_reset();
      stall_req = 5'b00001; flush_req = 5'b01000;
      #1;
      chk("c0_kill", kill, 5'b00110);
      chk("c0_stall", stall, 5'b00001);
      tick();
      flush_req = '0;
      #1;
      chk("c1_pend", redirect_pending, 1);
      chk("c1_kill", kill, 0);
      tick();
      chk("c2_pend", redirect_pending, 1);
      chk("c2_kill", kill, 0);
      tick();
      stall_req = '0;
      #1;
      chk("c3_kill", kill, 5'b00001);
      tick();
      chk("c4_pend", redirect_pending, 0);
      chk("c4_kill", kill, 0);

      do_reset();
      stall_req = 5'b00001;
      for (int c = 0; c < 1023; c++) tick();
      chk("wd_1023_hang", hang, 0);
      tick();
      chk("wd_hang", hang, 1);
      chk("wd_cnt", stall_cnt, 1024);
      stall_req = '0; cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("wd_clr_cnt", stall_cnt, 0);
      chk("wd_clr_hang", hang, 1);

      // reset drops a pending redirect
      stall_req = 5'b00001; flush_req = 5'b01000;
      tick();
      flush_req = '0;
      #1;
      chk("rp_pend", redirect_pending, 1);
      rst = 1'b1;
      #1;
      chk("rp_rst_stall", stall, 0);
      chk("rp_rst_kill", kill, 0);
      chk("rp_rst_pend", redirect_pending, 0);
      chk("rp_rst_hang", hang, 0);
      chk("rp_rst_cnt", stall_cnt, 0);
      tick();
      rst = 1'b0; stall_req = '0;
      #1;
      chk("rp_after_pend", redirect_pending, 0);
      chk("rp_after_hang", hang, 0);
      chk("rp_after_cnt", stall_cnt, 0);
      chk("rp_after_kill", kill, 0);

      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < S; i++) begin
            stall_req[i] = ($urandom_range(0, 4) == 0);
            flush_req[i] = ($urandom_range(0, 5) == 0);
         end
         cnt_clr = ($urandom_range(0, 40) == 0);
         rst = ($urandom_range(0, 150) == 0);
         #3;
         model(stall_req, flush_req, fp_m, es, eb, ek, r0);
         if (rst) begin
            es = '0; eb = '0; ek = '0;
         end
         chk("rnd_stall", stall, es);
         chk("rnd_bubble", bubble, eb);
         chk("rnd_kill", kill, ek);
         chk("rnd_pend", redirect_pending, rst ? 0 : fp_m);
         chk("rnd_cnt", stall_cnt, rst ? 0 : cnt_m[31:0]);
         chk("rnd_hang", hang, rst ? 0 : hang_m);
         if (rst) begin
            fp_m = 0; hang_m = 0; cnt_m = 0; consec_m = 0;
         end else begin
            fp_m = r0 && stall_req[0];
            if (cnt_clr) cnt_m = 0;
            else if (stall_req != 0 && cnt_m < 64'hFFFF_FFFF) cnt_m++;
            consec_m = (stall_req != 0) ? ((consec_m < 65535) ? consec_m + 1 : consec_m) : 0;
            if (stall_req != 0 && consec_m == 1024) hang_m = 1;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline hazard controller for the in-order core. It replaces the fixed 4-output stall chain and generalises it to STAGES boundaries. It adds bubble insertion, flush/kill with a held fetch redirect, a stall-cycle performance counter and a stall watchdog. It sits beside the pipeline and drives the hold/clear controls of the PC register and of every inter-stage register.

Parameters:
STAGES, 5, number of controlled boundaries; index 0 = PC register (youngest), index STAGES-1 = oldest register (ex_mem in default build).
CNT_W, 32, width of the stall-cycle performance counter.
WDOG_W, 16, width of the consecutive-stall counter.
WDOG_LIMIT, 1024, consecutive stall cycles that set hang; must be < 2^WDOG_W.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall_req  in  STAGES  per-stage stall request, bit i from the stage writing boundary i
flush_req  in  STAGES  per-stage flush request (branch resolve/exception); bit 0 ignored
cnt_clr  in  1  synchronous clear of stall_cnt
stall  out  STAGES  hold boundary i this cycle
bubble  out  STAGES  load NOP into boundary i this cycle
kill  out  STAGES  clear boundary i; kill[0] = PC takes redirect this cycle
redirect_pending  out  1  flush accepted but fetch busy; redirect still owed
stall_cnt  out  CNT_W  saturating count of cycles with raw stall chain bit 0 set
hang  out  1  sticky watchdog flag

Behaviour:
- rst high: every output forced 0 combinationally. fpend, stall_cnt, consec and hang are cleared at the edge.
- Raw chain (combinational):
  - s[STAGES-1] = stall_req[STAGES-1].
  - s[i] = stall_req[i] | s[i+1].
  - Older stalls always propagate to younger stages.
- Effective flush: fl[i] = flush_req[i] & ~s[i], for i ≥ 1. A flush from a stalled stage is ignored; the requester must hold it.
- kill[j] for j ≥ 1 = OR of fl[i] over i > j. Oldest flush dominates; simultaneous flushes are just ORed.
- Fetch redirect:
  - req0 = (OR of fl[i], i ≥ 1) | fpend.
  - kill[0] = req0 & ~stall_req[0].
  - fpend next = req0 & stall_req[0].
  - redirect_pending = fpend.
  - A new flush while fpend=1 merges into the same pending redirect; the requester re-presents the target PC.
- stall[j] = s[j] & ~kill[j]. Kill overrides stall.
- bubble[0] = 0. For j ≥ 1, bubble[j] = s[j-1] & ~s[j] & ~kill[j]. Kill and bubble are never both 1.
- stall_cnt:
  - cnt_clr has priority and loads 0.
  - Otherwise it increments when s[0] = 1 and the counter is not all-ones; it saturates at all-ones.
- Watchdog:
  - consec increments (saturating) while s[0] = 1 and clears when s[0] = 0.
  - hang is set at the edge where consec reaches WDOG_LIMIT, i.e. after WDOG_LIMIT consecutive stall cycles.
  - hang stays set until rst; cnt_clr does not clear it.
- Latency:
  - stall, bubble, kill[j≥1] and kill[0] (when no pending) are zero-cycle combinational.
  - redirect_pending is 1 cycle after the accepted flush.
  - A pending redirect is issued in the first cycle stall_req[0] = 0.
- rst while fpend = 1: the pending redirect is dropped. The core restarts from the reset PC.

Test Plan:
- STAGES=5, stall_req=5'b01000 -> stall=5'b01111, bubble=5'b10000, kill=0, stall_cnt +1 per cycle.
- flush_req=5'b01000, stall_req=0 -> kill=5'b00111, stall=0, bubble=0, redirect_pending stays 0.
- flush_req[3] one cycle (c0) with stall_req[0]=1 over c0–c2, dropping at c3:
  - c0: kill=5'b00110.
  - c1–c2: redirect_pending=1, kill=0.
  - c3: kill[0]=1.
  - c4: redirect_pending=0.
- flush_req[2] with stall_req[4]=1 -> flush masked: kill=0, stall=5'b11111.
- WDOG_LIMIT=1024, stall_req[0] held 1024 cycles from a clean reset:
  - hang=1 after the 1024th edge, stall_cnt=1024.
  - Release stall, pulse cnt_clr -> stall_cnt=0 next cycle, hang remains 1.
- Assert rst during redirect_pending=1 -> all outputs 0 immediately.
  - After rst falls: redirect_pending=0, hang=0, stall_cnt=0, no kill[0].
